// File: rtl/sram_range_filler.sv
// rtl/sram_range_filler.sv - fills an inclusive SRAM address range with a constant or incrementing pattern
// Owns the SRAM ports only while busy; completion interrupt held until acknowledged.
module sram_range_filler #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                cfg_mode,
  input  logic [DATA_W-1:0]   cfg_pattern,
  input  logic [ADDR_W-1:0]   cfg_start_addr,
  input  logic [ADDR_W-1:0]   cfg_end_addr,
  input  logic                irq_ack,
  output logic                done_irq,
  output logic                busy,
  output logic                err,
  output logic                aborted,
  output logic [ADDR_W:0]     words_written,
  output logic                ce_a,
  output logic                we_a,
  output logic [ADDR_W-1:0]   addr_a,
  output logic [DATA_W-1:0]   wdata_a,
  output logic [DATA_W/8-1:0] wmask_a,
  output logic                ce_b,
  output logic                we_b,
  output logic [ADDR_W-1:0]   addr_b,
  output logic [DATA_W-1:0]   wdata_b,
  output logic [DATA_W/8-1:0] wmask_b
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, state_n;

  logic              mode_q;
  logic [DATA_W-1:0] pat_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  off_q;   // offset of the next beat to issue

  logic              issue, en_b, accept;
  logic [CNT_W-1:0]  k, kb, len_in, len_src, inc;
  logic              mode_src;
  logic [DATA_W-1:0] pat_src, data_a_n, data_b_n;
  logic [ADDR_W-1:0] base_src, addr_a_n, addr_b_n;

  assign len_in = {1'b0, cfg_end_addr} - {1'b0, cfg_start_addr} + CNT_W'(1);
  assign accept = (state == IDLE) && start;

  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    k        = off_q;
    mode_src = mode_q;
    pat_src  = pat_q;
    base_src = base_q;
    len_src  = len_q;
    case (state)
      IDLE: begin
        if (start) begin
          // The first beat is built straight from the inputs, cfg is latched on the same edge
          k        = '0;
          mode_src = cfg_mode;
          pat_src  = cfg_pattern;
          base_src = cfg_start_addr;
          len_src  = len_in;
          if (cfg_start_addr > cfg_end_addr) begin
            state_n = DONE;
          end else begin
            state_n = FILL;
            issue   = 1'b1;
          end
        end
      end
      FILL: begin
        if (abort || (off_q >= len_q)) state_n = DONE;
        else                           issue   = 1'b1;
      end
      DONE: begin
        if (irq_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    kb       = k + CNT_W'(1);
    en_b     = issue && (NUM_PORTS == 2) && (kb < len_src);
    addr_a_n = base_src + k[ADDR_W-1:0];
    addr_b_n = base_src + kb[ADDR_W-1:0];
    data_a_n = pat_src + (mode_src ? DATA_W'(k)  : '0);
    data_b_n = pat_src + (mode_src ? DATA_W'(kb) : '0);
    inc      = en_b ? CNT_W'(2) : CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      pat_q         <= '0;
      base_q        <= '0;
      len_q         <= '0;
      off_q         <= '0;
      err           <= 1'b0;
      aborted       <= 1'b0;
      words_written <= '0;
      ce_a          <= 1'b0;
      ce_b          <= 1'b0;
      addr_a        <= '0;
      addr_b        <= '0;
      wdata_a       <= '0;
      wdata_b       <= '0;
    end else begin
      state   <= state_n;
      ce_a    <= issue;
      ce_b    <= en_b;
      addr_a  <= issue ? addr_a_n : '0;
      wdata_a <= issue ? data_a_n : '0;
      addr_b  <= en_b ? addr_b_n : '0;
      wdata_b <= en_b ? data_b_n : '0;
      if (accept) begin
        mode_q        <= cfg_mode;
        pat_q         <= cfg_pattern;
        base_q        <= cfg_start_addr;
        len_q         <= len_in;
        off_q         <= CNT_W'(NUM_PORTS);
        err           <= cfg_start_addr > cfg_end_addr;
        aborted       <= 1'b0;
        words_written <= issue ? inc : '0;
      end else if (issue) begin
        off_q         <= off_q + CNT_W'(NUM_PORTS);
        words_written <= words_written + inc;
      end
      if ((state == FILL) && abort) aborted <= 1'b1;
    end
  end

  assign busy     = (state == FILL);
  assign done_irq = (state == DONE);
  assign we_a     = ce_a;
  assign we_b     = ce_b;
  assign wmask_a  = {MASK_W{ce_a}};
  assign wmask_b  = {MASK_W{ce_b}};
endmodule
